// File: rtl/pipe_pkg.sv
// Shared types for the pipeline control block: FSM state encoding and boot counter sizing.
package pipe_pkg;

    localparam int unsigned ST_W = 2;

    typedef enum logic [ST_W-1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } st_e;

    // Width of a counter that must hold values 0 .. cyc-1 (at least one bit).
    function automatic int unsigned boot_cnt_w(input int unsigned cyc);
        return (cyc <= 2) ? 1 : $clog2(cyc);
    endfunction

endpackage

// File: rtl/pipe_perf_cnt.sv
// Free-running wrap-around event counter with increment enable and freeze.
module pipe_perf_cnt
    import pipe_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             freeze,
    output logic [CNT_W-1:0] count
);

    // Count one event per cycle unless frozen; wraps naturally at 2^CNT_W.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && !freeze) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Stall/flush/valid sequencer for the 5-stage pipeline plus boot/run/halt FSM.
// Optional feature macro: PIPE_PERF_EN adds four performance counters.
module pipe_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned BOOT_CYC = 2
`ifdef PIPE_PERF_EN
    ,
    parameter int unsigned CNT_W    = 32
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_use,
    input  logic             ifu_rvalid,
    input  logic             ex_busy,
    input  logic             lsu_busy,
    input  logic             ex_redirect,
    input  logic             wb_ebreak,
    output logic             fetch_en,
    output logic             pc_hold,
    output logic             hold_id,
    output logic             hold_ex,
    output logic             hold_mem,
    output logic             hold_wb,
    output logic             flush_id,
    output logic             flush_ex,
    output logic             v_id,
    output logic             v_ex,
    output logic             v_mem,
    output logic             v_wb,
    output logic             halted
`ifdef PIPE_PERF_EN
    ,
    output logic [CNT_W-1:0] perf_cycle,
    output logic [CNT_W-1:0] perf_retire,
    output logic [CNT_W-1:0] perf_stall,
    output logic [CNT_W-1:0] perf_flush
`endif
);

    localparam int unsigned             BOOT_CNT_W = boot_cnt_w(BOOT_CYC);
    localparam logic [BOOT_CNT_W-1:0]   BOOT_LAST  = BOOT_CNT_W'(BOOT_CYC - 1);

    st_e                   state;
    logic [BOOT_CNT_W-1:0] boot_cnt;
    logic                  run;
    logic                  s_mem;
    logic                  s_ex;
    logic                  redir;
    logic                  lu;
    logic                  ebreak_ret;

    // Stall chain, evaluated back to front; only active while running.
    always_comb begin
        run        = (state == RUN);
        s_mem      = run & v_mem & lsu_busy;
        s_ex       = (run & v_ex & ex_busy) | s_mem;
        redir      = run & ex_redirect & v_ex & ~s_ex;
        lu         = run & load_use & v_id & v_ex & ~redir;
        ebreak_ret = run & v_wb & wb_ebreak;
    end

    // Per-stage hold and bubble controls; BOOT and HALT freeze everything.
    always_comb begin
        hold_wb  = 1'b1;
        hold_mem = 1'b1;
        hold_ex  = 1'b1;
        hold_id  = 1'b1;
        pc_hold  = 1'b1;
        flush_id = 1'b0;
        flush_ex = 1'b0;
        if (run) begin
            hold_wb  = 1'b0;
            hold_mem = s_mem;
            hold_ex  = s_ex;
            hold_id  = s_ex | lu;
            pc_hold  = hold_id | ~fetch_en | ~ifu_rvalid;
            flush_id = redir;
            flush_ex = redir | (lu & ~s_ex);
        end
    end

    // Boot/run/halt FSM with registered fetch enable and halt flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= BOOT;
            boot_cnt <= '0;
            fetch_en <= 1'b0;
            halted   <= 1'b0;
        end else begin
            case (state)
                BOOT: begin
                    if (boot_cnt == BOOT_LAST) begin
                        state    <= RUN;
                        fetch_en <= 1'b1;
                    end else begin
                        boot_cnt <= boot_cnt + BOOT_CNT_W'(1);
                    end
                end
                RUN: begin
                    if (ebreak_ret) begin
                        state    <= HALT;
                        fetch_en <= 1'b0;
                        halted   <= 1'b1;
                    end
                end
                HALT: begin
                    state <= HALT;
                end
                default: begin
                    state    <= BOOT;
                    boot_cnt <= '0;
                    fetch_en <= 1'b0;
                    halted   <= 1'b0;
                end
            endcase
        end
    end

    // Inter-stage valid bits; an ebreak leaving WB retires once and is not repeated.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v_id  <= 1'b0;
            v_ex  <= 1'b0;
            v_mem <= 1'b0;
            v_wb  <= 1'b0;
        end else if (run) begin
            v_wb  <= (s_mem | ebreak_ret) ? 1'b0 : v_mem;
            v_mem <= s_mem ? v_mem : (s_ex ? 1'b0 : v_ex);
            v_ex  <= s_ex ? v_ex : (flush_ex ? 1'b0 : v_id);
            v_id  <= hold_id ? v_id : (flush_id ? 1'b0 : (fetch_en & ifu_rvalid));
        end
    end

`ifdef PIPE_PERF_EN
    logic halt_st;
    assign halt_st = (state == HALT);

    pipe_perf_cnt #(.CNT_W(CNT_W)) u_cnt_cycle (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc    (run),
        .freeze (halt_st),
        .count  (perf_cycle)
    );

    pipe_perf_cnt #(.CNT_W(CNT_W)) u_cnt_retire (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc    (run & v_wb),
        .freeze (halt_st),
        .count  (perf_retire)
    );

    pipe_perf_cnt #(.CNT_W(CNT_W)) u_cnt_stall (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc    (run & hold_id),
        .freeze (halt_st),
        .count  (perf_stall)
    );

    pipe_perf_cnt #(.CNT_W(CNT_W)) u_cnt_flush (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc    (redir),
        .freeze (halt_st),
        .count  (perf_flush)
    );
`endif

endmodule
